// File: rtl/relock_pkg.sv
// rtl/relock_pkg.sv - shared state encodings and default configuration for the relock controller
package relock_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_SETTLING = 2'b10,
        ST_ILLEGAL  = 2'b11
    } relock_state_e;

    localparam int LOSTCNT_W = 8;

    localparam int LO_DEF_C    = 'h2000;
    localparam int HI_DEF_C    = 'h2800;
    localparam int SWMIN_DEF_C = 'h1800;
    localparam int SWMAX_DEF_C = 'h5400;
    localparam int STEP_DEF_C  = 'h80;

endpackage

// File: rtl/relock_channel.sv
// rtl/relock_channel.sv - one lock channel: compare pipeline, lock FSM, settle counter, sweep and config
module relock_channel
    import relock_pkg::*;
#(
    parameter int              W          = 16,
    parameter int              FRAC       = 16,
    parameter int              SETTLE_CYC = 100000000,
    parameter logic [W-1:0]    LO_DEF     = W'(LO_DEF_C),
    parameter logic [W-1:0]    HI_DEF     = W'(HI_DEF_C),
    parameter logic [W-1:0]    SWMIN_DEF  = W'(SWMIN_DEF_C),
    parameter logic [W-1:0]    SWMAX_DEF  = W'(SWMAX_DEF_C),
    parameter logic [W+FRAC-1:0] STEP_DEF = (W+FRAC)'(STEP_DEF_C)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic signed [W-1:0]         trans_i,
    input  logic                        cfg_we_i,
    input  logic signed [W-1:0]         cfg_lo_i,
    input  logic signed [W-1:0]         cfg_hi_i,
    input  logic signed [W-1:0]         cfg_swmin_i,
    input  logic signed [W-1:0]         cfg_swmax_i,
    input  logic [W+FRAC-1:0]           cfg_step_i,
    output logic                        servo_on_o,
    output logic [1:0]                  state_o,
    output logic signed [W-1:0]         sweep_o,
    output logic [LOSTCNT_W-1:0]        lostcnt_o
);

    localparam int AW    = W + FRAC;
    localparam int EW    = AW + 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    logic signed [W-1:0]    trans_q;
    logic                   below_q, above_q;
    logic signed [W-1:0]    lo_q, hi_q, swmin_q, swmax_q;
    logic [AW-1:0]          step_q;
    relock_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LOSTCNT_W-1:0]   lost_q, lost_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic                   dir_up_q, dir_up_d;
    logic signed [EW-1:0]   acc_e, min_e, max_e, step_e, sum_e, diff_e;

    // Input sample register, registered threshold compare and config registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            trans_q <= '0;
            below_q <= 1'b0;
            above_q <= 1'b0;
            lo_q    <= LO_DEF;
            hi_q    <= HI_DEF;
            swmin_q <= SWMIN_DEF;
            swmax_q <= SWMAX_DEF;
            step_q  <= STEP_DEF;
        end else begin
            trans_q <= trans_i;
            below_q <= (trans_q < lo_q);
            above_q <= (trans_q >= hi_q);
            if (cfg_we_i) begin
                lo_q    <= cfg_lo_i;
                hi_q    <= cfg_hi_i;
                swmin_q <= cfg_swmin_i;
                swmax_q <= cfg_swmax_i;
                step_q  <= cfg_step_i;
            end
        end
    end

    // Lock state, settle counter, loss counter and sweep accumulator.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= ST_UNLOCKED;
            cnt_q    <= '0;
            lost_q   <= '0;
            acc_q    <= {SWMIN_DEF, {FRAC{1'b0}}};
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            acc_q    <= acc_d;
            dir_up_q <= dir_up_d;
        end
    end

    // Lock FSM next state: unlock on below, start settling on above, lock after the settle window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        case (state_q)
            ST_LOCKED: begin
                if (below_q) begin
                    state_d = ST_UNLOCKED;
                    if (lost_q != {LOSTCNT_W{1'b1}}) begin
                        lost_d = lost_q + 1'b1;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (above_q) begin
                    state_d = ST_SETTLING;
                    cnt_d   = '0;
                end
            end
            ST_SETTLING: begin
                if (below_q) begin
                    state_d = ST_UNLOCKED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOCKED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // Triangular sweep, one extra bit of headroom so neither the step nor the limits can wrap.
    always_comb begin
        acc_e    = {acc_q[AW-1], acc_q};
        min_e    = {swmin_q[W-1], swmin_q, {FRAC{1'b0}}};
        max_e    = {swmax_q[W-1], swmax_q, {FRAC{1'b0}}};
        step_e   = {1'b0, step_q};
        sum_e    = acc_e + step_e;
        diff_e   = acc_e - step_e;
        acc_d    = acc_q;
        dir_up_d = dir_up_q;
        if (state_q == ST_UNLOCKED) begin
            if (acc_e > max_e) begin
                acc_d    = max_e[AW-1:0];
                dir_up_d = 1'b0;
            end else if (acc_e < min_e) begin
                acc_d    = min_e[AW-1:0];
                dir_up_d = 1'b1;
            end else if (dir_up_q) begin
                if (sum_e >= max_e) begin
                    acc_d    = max_e[AW-1:0];
                    dir_up_d = 1'b0;
                end else begin
                    acc_d = sum_e[AW-1:0];
                end
            end else begin
                if (diff_e <= min_e) begin
                    acc_d    = min_e[AW-1:0];
                    dir_up_d = 1'b1;
                end else begin
                    acc_d = diff_e[AW-1:0];
                end
            end
        end
    end

    assign state_o    = state_q;
    assign servo_on_o = (state_q == ST_LOCKED) || (state_q == ST_SETTLING);
    assign sweep_o    = acc_q[AW-1:FRAC];
    assign lostcnt_o  = lost_q;

endmodule

// File: rtl/multi_relock_ctrl.sv
// rtl/multi_relock_ctrl.sv - multi-channel relock controller top: cfg decode, error pulse, output packing
module multi_relock_ctrl
    import relock_pkg::*;
#(
    parameter int              NCH        = 2,
    parameter int              W          = 16,
    parameter int              FRAC       = 16,
    parameter int              SETTLE_CYC = 100000000,
    parameter logic [W-1:0]    LO_DEF     = W'(LO_DEF_C),
    parameter logic [W-1:0]    HI_DEF     = W'(HI_DEF_C),
    parameter logic [W-1:0]    SWMIN_DEF  = W'(SWMIN_DEF_C),
    parameter logic [W-1:0]    SWMAX_DEF  = W'(SWMAX_DEF_C),
    parameter logic [W+FRAC-1:0] STEP_DEF = (W+FRAC)'(STEP_DEF_C),
    localparam int             CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NCH*W-1:0]            trans_in,
    input  logic                        cfg_load_in,
    input  logic [CH_W-1:0]             cfg_ch_in,
    input  logic [W-1:0]                cfg_lo_in,
    input  logic [W-1:0]                cfg_hi_in,
    input  logic [W-1:0]                cfg_swmin_in,
    input  logic [W-1:0]                cfg_swmax_in,
    input  logic [W+FRAC-1:0]           cfg_step_in,
    output logic                        cfg_err_out,
    output logic [NCH-1:0]              servo_on_out,
    output logic [NCH*2-1:0]            state_out,
    output logic [NCH*W-1:0]            sweep_out,
    output logic [NCH*LOSTCNT_W-1:0]    lostcnt_out
);

    logic [31:0] ch_ext;
    logic        cfg_bad;
    logic        load_ok;
    logic        cfg_err_q, cfg_err_d;

    // A load is refused for an out-of-range channel or inverted threshold/sweep limits.
    always_comb begin
        ch_ext    = 32'(cfg_ch_in);
        cfg_bad   = (ch_ext >= 32'(NCH))
                 || ($signed(cfg_swmin_in) > $signed(cfg_swmax_in))
                 || ($signed(cfg_lo_in) > $signed(cfg_hi_in));
        load_ok   = cfg_load_in && !cfg_bad;
        cfg_err_d = cfg_load_in && cfg_bad;
    end

    // Rejection is reported as a single-cycle pulse after the offending load.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err_out = cfg_err_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        relock_channel #(
            .W          (W),
            .FRAC       (FRAC),
            .SETTLE_CYC (SETTLE_CYC),
            .LO_DEF     (LO_DEF),
            .HI_DEF     (HI_DEF),
            .SWMIN_DEF  (SWMIN_DEF),
            .SWMAX_DEF  (SWMAX_DEF),
            .STEP_DEF   (STEP_DEF)
        ) u_ch (
            .clk_i       (clk_in),
            .rstn_i      (rst_in),
            .trans_i     (trans_in[k*W +: W]),
            .cfg_we_i    (load_ok && (ch_ext == 32'(k))),
            .cfg_lo_i    (cfg_lo_in),
            .cfg_hi_i    (cfg_hi_in),
            .cfg_swmin_i (cfg_swmin_in),
            .cfg_swmax_i (cfg_swmax_in),
            .cfg_step_i  (cfg_step_in),
            .servo_on_o  (servo_on_out[k]),
            .state_o     (state_out[k*2 +: 2]),
            .sweep_o     (sweep_out[k*W +: W]),
            .lostcnt_o   (lostcnt_out[k*LOSTCNT_W +: LOSTCNT_W])
        );
    end

endmodule
